reload_counter_arbiter: RTL and testbench

- Shares one 4-bit self-reloading counter between NUM_REQ requesters.
- Grants the counter to one requester at a time and programs it with that requester's reload value.
- Holds the grant (a "lease") for LEASE_WRAPS counter wrap-arounds, then releases it.
- Sits between requester logic and the counter's load_i / load_val_i / count_o ports.

---
 rtl/reload_counter_arbiter.sv | 179 +++++++++++++++++
 tb/tb_reload_counter_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reload_counter_arbiter.sv
// reload_counter_arbiter
//   Shares one self-reloading counter between NUM_REQ requesters. The block
//   grants the counter to one requester at a time and loads it with that
//   requester's reload value. The grant (a "lease") lasts for LEASE_WRAPS
//   counter wrap-arounds. The owner can end it early by dropping its request.
//
//   Optional build macro: RLC_ROUND_ROBIN_EN
//     defined   -> round-robin arbitration. The search starts one past the
//                  last owner.
//     undefined -> fixed priority (the lowest index wins). No pointer
//                  register is built.
module reload_counter_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 4,
    parameter int LEASE_WRAPS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*WIDTH-1:0]   load_val_i,
    input  logic [WIDTH-1:0]           count_i,
    output logic                       cnt_load_o,
    output logic [WIDTH-1:0]           cnt_load_val_o,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o
);

    localparam int OW = $clog2(NUM_REQ);

    // Wrap count at which the next observed wrap completes the lease.
    localparam logic [7:0] LAST_WRAP = 8'(LEASE_WRAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_LEASE   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [OW-1:0]        r_owner;
    logic [WIDTH-1:0]     r_val;
    logic [7:0]           r_wraps;

    logic                 w_any_req;
    logic [OW-1:0]        w_pick;
    logic                 w_wrap;
    logic [NUM_REQ-1:0]   w_owner_oh;

    // The counter reads all-ones in its last cycle before it reloads.
    assign w_wrap     = (count_i == {WIDTH{1'b1}});
    assign w_owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;

    assign owner_o        = r_owner;
    assign cnt_load_val_o = r_val;

`ifdef RLC_ROUND_ROBIN_EN
    logic [OW-1:0] r_ptr;
    logic [OW-1:0] w_idx;

    // Round-robin pick: scan upward from one past the pointer, wrapping to 0.
    always_comb begin
        // NOTE: every variable gets a default before any branch; otherwise a path that skips it infers a latch.
        w_any_req = 1'b0;
        w_pick    = '0;
        w_idx     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = OW'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_any_req && req_i[w_idx]) begin
                w_any_req = 1'b1;
                w_pick    = w_idx;
            end
        end
    end

    // The pointer remembers the last owner. After reset requester 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= OW'(NUM_REQ - 1);
        end else if (r_state == S_RELEASE) begin
            r_ptr <= r_owner;
        end
    end
`else
    // Fixed-priority pick: the lowest requesting index wins.
    always_comb begin
        w_any_req = 1'b0;
        w_pick    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_any_req && req_i[i]) begin
                w_any_req = 1'b1;
                w_pick    = OW'(i);
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments, so all flops update together from pre-edge values.
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Lease bookkeeping: capture the owner and its value at grant, and count wraps during the lease.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner <= '0;
            r_val   <= '0;
            r_wraps <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_pick;
                        r_val   <= load_val_i[w_pick*WIDTH +: WIDTH];
                    end
                end
                S_LOAD: begin
                    r_wraps <= '0;
                end
                S_LEASE: begin
                    // Saturate, so a very long lease never aliases back to zero.
                    if (w_wrap && (r_wraps != 8'hFF)) begin
                        r_wraps <= r_wraps + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and Moore outputs. All outputs depend only on registered state.
    always_comb begin
        w_next_state = r_state;
        cnt_load_o   = 1'b0;
        gnt_o        = '0;
        done_o       = '0;
        busy_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                gnt_o        = w_owner_oh;
                cnt_load_o   = 1'b1;
                busy_o       = 1'b1;
                w_next_state = S_LEASE;
            end
            S_LEASE: begin
                gnt_o  = w_owner_oh;
                busy_o = 1'b1;
                // An early release by the owner overrides the wrap count.
                if (!req_i[r_owner]) begin
                    w_next_state = S_RELEASE;
                end else if (w_wrap && (r_wraps == LAST_WRAP)) begin
                    w_next_state = S_RELEASE;
                end
            end
            S_RELEASE: begin
                done_o       = w_owner_oh;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reload_counter_arbiter.sv
// Directed bench for reload_counter_arbiter. It uses a behavioural
// self-reloading 4-bit counter and per-cycle invariant checks.
module tb_reload_counter_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int WIDTH       = 4;
    localparam int LEASE_WRAPS = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ*WIDTH-1:0] load_val_i;
    logic [WIDTH-1:0]         count_i;
    logic                     cnt_load_o;
    logic [WIDTH-1:0]         cnt_load_val_o;
    logic [NUM_REQ-1:0]       gnt_o;
    logic [NUM_REQ-1:0]       done_o;
    logic                     busy_o;
    logic [1:0]               owner_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reload_counter_arbiter #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .LEASE_WRAPS(LEASE_WRAPS)
    ) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .load_val_i(load_val_i),
        .count_i(count_i), .cnt_load_o(cnt_load_o), .cnt_load_val_o(cnt_load_val_o),
        .gnt_o(gnt_o), .done_o(done_o), .busy_o(busy_o), .owner_o(owner_o)
    );

    // Self-reloading counter: load_i sets the count and the reload value. When it passes all-ones it restarts from the reload value.
    logic [WIDTH-1:0] r_reload;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_i  <= '0;
            r_reload <= '0;
        end else if (cnt_load_o) begin
            count_i  <= cnt_load_val_o;
            r_reload <= cnt_load_val_o;
        end else if (count_i == 4'hF) begin
            count_i  <= r_reload;
        end else begin
            count_i  <= count_i + 4'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits at most budget cycles for a grant. Returns the grant and the cycles waited.
    task automatic wait_grant(input int budget, output logic [3:0] g, output int cycles);
        g = '0;
        cycles = 0;
        while (cycles < budget && g == 4'b0) begin
            @(negedge clk);
            cycles++;
            g = gnt_o;
        end
    endtask

    task automatic wait_done(input int budget, output logic [3:0] d, output int cycles);
        d = '0;
        cycles = 0;
        while (cycles < budget && d == 4'b0) begin
            @(negedge clk);
            cycles++;
            d = done_o;
        end
    endtask

    // Invariants checked every cycle outside reset.
    logic [3:0] prev_gnt = '0;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("gnt_onehot0", 32'($onehot0(gnt_o)), 1);
            check("done_onehot0", 32'($onehot0(done_o)), 1);
            check("gnt_done_excl", 32'((|gnt_o) && (|done_o)), 0);
            if (cnt_load_o) check("load_first_cycle", 32'((gnt_o != 0) && (prev_gnt == 0)), 1);
            prev_gnt <= gnt_o;
        end else begin
            prev_gnt <= '0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g;
        logic [3:0] d;
        int         c;
        int         c2;
        logic [3:0] seq [8];
        logic [3:0] order [5];

        seq = '{4'hC, 4'hD, 4'hE, 4'hF, 4'hC, 4'hD, 4'hE, 4'hF};
`ifdef RLC_ROUND_ROBIN_EN
        order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010};
`else
        order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif

        // Outputs while reset is held.
        reset = 1'b0; req_i = '0; load_val_i = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt_o, 0);
        check("rst_done", done_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_load", cnt_load_o, 0);
        check("rst_owner", owner_o, 0);
        check("rst_val", cnt_load_val_o, 0);
        reset = 1'b1;

        // Requester 2 with reload value C.
        @(negedge clk);
        req_i = 4'b0100; load_val_i = 16'h0C00;
        @(negedge clk);
        check("b_gnt", gnt_o, 4'b0100);
        check("b_load", cnt_load_o, 1);
        check("b_val", cnt_load_val_o, 4'hC);
        check("b_busy", busy_o, 1);
        check("b_owner", owner_o, 2);
        load_val_i = 16'h0300;     // a change after the grant must not matter
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("b_count", count_i, seq[k]);
            check("b_lease_gnt", gnt_o, 4'b0100);
            check("b_lease_load", cnt_load_o, 0);
        end
        @(negedge clk);
        check("b_done", done_o, 4'b0100);
        check("b_rel_gnt", gnt_o, 0);
        check("b_rel_busy", busy_o, 0);
        req_i = '0;
        @(negedge clk);
        check("b_done_pulse", done_o, 0);

        // Reset asserted in the middle of a lease.
        req_i = 4'b0010; load_val_i = 16'h0090;
        wait_grant(10, g, c);
        check("c_gnt", g, 4'b0010);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("c_async_gnt", gnt_o, 0);
        check("c_async_busy", busy_o, 0);
        check("c_async_owner", owner_o, 0);
        check("c_async_val", cnt_load_val_o, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1; req_i = 4'b1111;
        wait_grant(10, g, c);
        check("c_first_winner", g, 4'b0001);

        // Constant request pattern 1011 with value F: each lease is two cycles long.
        @(negedge clk);
        reset = 1'b0; req_i = '0; load_val_i = 16'hFFFF;
        @(negedge clk);
        reset = 1'b1; req_i = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            wait_grant(10, g, c);
            check("d_order_gnt", g, order[k]);
            if (k > 0) check("d_gap", c, 2);
            wait_done(20, d, c2);
            check("d_order_done", d, order[k]);
            if (k == 0) check("d_f_lease_len", c2, 3);
        end
        req_i = '0;

        // Early release: requester 1 drops its request two cycles into its lease.
        @(negedge clk);
        reset = 1'b0; load_val_i = 16'h0500;
        @(negedge clk);
        reset = 1'b1; req_i = 4'b0110;
        wait_grant(10, g, c);
        check("e_gnt", g, 4'b0010);
        @(negedge clk);
        check("e_l1_count", count_i, 4'h0);
        @(negedge clk);
        check("e_l2_count", count_i, 4'h1);
        req_i = 4'b0100;
        @(negedge clk);
        check("e_done", done_o, 4'b0010);
        check("e_rel_gnt", gnt_o, 0);
        wait_grant(10, g, c);
        check("e_next_gnt", g, 4'b0100);
        check("e_next_gap", c, 2);
        check("e_next_val", cnt_load_val_o, 4'h5);
        check("e_next_owner", owner_o, 2);
        @(negedge clk);
        check("e_next_count", count_i, 4'h5);
        req_i = '0;
        wait_done(10, d, c2);
        check("e_next_done", d, 4'b0100);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
